// File: rtl/adf4158_cfg_rx.sv
// adf4158_cfg_rx: receives the ADF4158 3-wire configuration stream,
// validates 32-bit frames on the le rising edge and mirrors committed
// words into a 10-slot register bank decoded from the control bits.
module adf4158_cfg_rx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        sdata,
  input  logic        le,
  input  logic        ce,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        frame_err,
  input  logic [3:0]  rd_slot,
  output logic [31:0] rd_data,
  output logic        ramp_en,
  output logic        configured
);

  localparam int NUM_SLOTS = 10;

  // Synchronizer bit positions: {ce, le, sdata, sclk}
  logic [3:0]  sync1_reg;
  logic [3:0]  sync2_reg;
  logic        sclk_d_reg;
  logic        le_d_reg;

  logic        sclk_s;
  logic        sdata_s;
  logic        le_s;
  logic        ce_s;
  logic        sclk_rise;
  logic        le_rise;

  logic [31:0] shift_reg;
  logic [5:0]  bit_cnt_reg;
  logic [31:0] word_reg;
  logic        word_valid_reg;
  logic        frame_err_reg;

  logic [31:0] bank_reg [0:NUM_SLOTS-1];
  logic [NUM_SLOTS-1:0] written_reg;

  logic        commit;
  logic [3:0]  slot_next;

  assign sclk_s  = sync2_reg[0];
  assign sdata_s = sync2_reg[1];
  assign le_s    = sync2_reg[2];
  assign ce_s    = sync2_reg[3];

  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign le_rise   = le_s & ~le_d_reg;

  // A frame commits only when exactly 32 bits were shifted while powered up
  assign commit = ce_s & le_rise & (bit_cnt_reg == 6'd32);

  // Two-flop synchronizers plus one-cycle-delayed copies for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= '0;
      sync2_reg  <= '0;
      sclk_d_reg <= 1'b0;
      le_d_reg   <= 1'b0;
    end else begin
      sync1_reg  <= {ce, le, sdata, sclk};
      sync2_reg  <= sync1_reg;
      sclk_d_reg <= sync2_reg[0];
      le_d_reg   <= sync2_reg[2];
    end
  end

  // Shift, bit counting and frame accept/reject; le rise takes priority over a same-cycle shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (!ce_s) begin
        bit_cnt_reg <= '0;
      end else if (le_rise) begin
        bit_cnt_reg <= '0;
        if (bit_cnt_reg == 6'd32) begin
          word_reg       <= shift_reg;
          word_valid_reg <= 1'b1;
        end else begin
          frame_err_reg  <= 1'b1;
        end
      end else if (sclk_rise && !le_s) begin
        shift_reg <= {shift_reg[30:0], sdata_s};
        if (bit_cnt_reg != 6'd33) begin
          bit_cnt_reg <= bit_cnt_reg + 6'd1;
        end
      end
    end
  end

  // Slot decode: R5 and R6 each own two slots selected by bit 23
  always_comb begin
    slot_next = {1'b0, shift_reg[2:0]};
    case (shift_reg[2:0])
      3'd5:    slot_next = shift_reg[23] ? 4'd6 : 4'd5;
      3'd6:    slot_next = shift_reg[23] ? 4'd8 : 4'd7;
      3'd7:    slot_next = 4'd9;
      default: slot_next = {1'b0, shift_reg[2:0]};
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi = gi + 1) begin : g_slot
      // Per-slot storage; contents survive power-down, written flag does not
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bank_reg[gi]    <= '0;
          written_reg[gi] <= 1'b0;
        end else if (!ce_s) begin
          written_reg[gi] <= 1'b0;
        end else if (commit && (slot_next == gi[3:0])) begin
          bank_reg[gi]    <= shift_reg;
          written_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Combinational bank read port; out-of-range indices read as zero
  always_comb begin
    rd_data = '0;
    if (rd_slot < 4'd10) begin
      rd_data = bank_reg[rd_slot];
    end
  end

  assign word       = word_reg;
  assign word_valid = word_valid_reg;
  assign frame_err  = frame_err_reg;
  assign ramp_en    = bank_reg[0][31];
  assign configured = &written_reg;

endmodule

// File: tb/tb_adf4158_cfg_rx.sv
// tb_adf4158_cfg_rx: drives serial frames into adf4158_cfg_rx and checks
// outputs against a slot-level reference model of the register bank.
module tb_adf4158_cfg_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        sdata = 1'b0;
  logic        le = 1'b0;
  logic        ce = 1'b1;
  logic [31:0] word;
  logic        word_valid;
  logic        frame_err;
  logic [3:0]  rd_slot = 4'd0;
  logic [31:0] rd_data;
  logic        ramp_en;
  logic        configured;

  int total = 0;
  int bad = 0;

  // Pulse counters observed by the monitor
  int wv_cnt = 0;
  int fe_cnt = 0;

  // Reference model
  logic [31:0] exp_bank [0:9];
  logic [31:0] exp_word;
  logic [9:0]  exp_written;

  adf4158_cfg_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .sdata      (sdata),
    .le         (le),
    .ce         (ce),
    .word       (word),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .rd_slot    (rd_slot),
    .rd_data    (rd_data),
    .ramp_en    (ramp_en),
    .configured (configured)
  );

  always #5 clk = ~clk;

  // Count pulse-cycles of word_valid and frame_err away from the active edge
  always @(negedge clk) begin
    if (word_valid === 1'b1) wv_cnt = wv_cnt + 1;
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
  end

  function automatic int slot_of(input logic [31:0] w);
    int ctl;
    ctl = int'(w[2:0]);
    if (ctl == 5) return w[23] ? 6 : 5;
    if (ctl == 6) return w[23] ? 8 : 7;
    if (ctl == 7) return 9;
    return ctl;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 10; i++) exp_bank[i] = '0;
    exp_word = '0;
    exp_written = '0;
  endtask

  task automatic model_commit(input logic [31:0] w);
    int s;
    s = slot_of(w);
    exp_bank[s] = w;
    exp_word = w;
    exp_written[s] = 1'b1;
  endtask

  task automatic shift_bits(input logic [63:0] bits, input int n, input int ph);
    for (int i = n - 1; i >= 0; i--) begin
      sdata = bits[i];
      sclk = 1'b0;
      repeat (ph) @(negedge clk);
      sclk = 1'b1;
      repeat (ph) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_le();
    le = 1'b1;
    repeat (4) @(negedge clk);
    le = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n, input int ph);
    shift_bits(bits, n, ph);
    pulse_le();
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++) begin
      logic [31:0] e;
      rd_slot = 4'(i);
      #1;
      e = (i < 10) ? exp_bank[i] : 32'h0;
      total++;
      if (rd_data !== e) begin
        bad++;
        $display("FAIL %s slot %0d: got %08h expected %08h", tag, i, rd_data, e);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    total++;
    if (word !== exp_word) begin
      bad++;
      $display("FAIL %s word: got %08h expected %08h", tag, word, exp_word);
    end
    total++;
    if (ramp_en !== exp_bank[0][31]) begin
      bad++;
      $display("FAIL %s ramp_en: got %0b expected %0b", tag, ramp_en, exp_bank[0][31]);
    end
    total++;
    if (configured !== (&exp_written)) begin
      bad++;
      $display("FAIL %s configured: got %0b expected %0b", tag, configured, &exp_written);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (word_valid !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses: got wv=%0b fe=%0b expected 0 0", word_valid, frame_err);
    end
    check_outputs("reset");
    check_bank("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    $display("test_reset: done");
  endtask

  task automatic test_single();
    int wv0, fe0;
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_frame({32'h0, 32'h8F084000}, 32, 2);
    model_commit(32'h8F084000);
    total++;
    if (wv_cnt - wv0 != 1 || fe_cnt != fe0) begin
      bad++;
      $display("FAIL single_pulses: got wv=%0d fe=%0d expected 1 0", wv_cnt - wv0, fe_cnt - fe0);
    end
    check_outputs("single");
    check_bank("single");
    $display("test_single: word=%08h ramp_en=%0b", word, ramp_en);
  endtask

  task automatic test_full_seq();
    logic [31:0] w;
    int wv0;
    logic [3:0] ctl [0:9];
    logic       b23 [0:9];
    ctl = '{4'd7, 4'd6, 4'd6, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    b23 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    wv0 = wv_cnt;
    for (int k = 0; k < 10; k++) begin
      w = $urandom;
      w[2:0] = ctl[k][2:0];
      w[23] = b23[k];
      send_frame({32'h0, w}, 32, 2);
      model_commit(w);
      if (k == 8 || k == 9) check_outputs($sformatf("seq%0d", k));
      $display("test_full_seq: sent %08h slot %0d", w, slot_of(w));
    end
    total++;
    if (wv_cnt - wv0 != 10) begin
      bad++;
      $display("FAIL seq_pulses: got %0d expected 10", wv_cnt - wv0);
    end
    check_bank("seq");
  endtask

  task automatic test_bad_frames();
    int wv0, fe0;
    logic [63:0] b;
    wv0 = wv_cnt; fe0 = fe_cnt;
    b = {$urandom, $urandom};
    send_frame(b, 31, 2);
    b = {$urandom, $urandom};
    send_frame(b, 33, 2);
    total++;
    if (fe_cnt - fe0 != 2 || wv_cnt != wv0) begin
      bad++;
      $display("FAIL bad_frames: got fe=%0d wv=%0d expected 2 0", fe_cnt - fe0, wv_cnt - wv0);
    end
    check_outputs("bad");
    check_bank("bad");
    $display("test_bad_frames: fe=%0d", fe_cnt - fe0);
  endtask

  task automatic test_ce_drop();
    int wv0, fe0;
    ce = 1'b0;
    exp_written = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (configured !== 1'b0) begin
      bad++;
      $display("FAIL ce_configured: got %0b expected 0", configured);
    end
    check_bank("ce_hold");
    wv0 = wv_cnt; fe0 = fe_cnt;
    send_frame({32'h0, $urandom}, 32, 2);
    send_frame({32'h0, $urandom}, 20, 2);
    total++;
    if (wv_cnt != wv0 || fe_cnt != fe0) begin
      bad++;
      $display("FAIL ce_frames: got wv=%0d fe=%0d expected 0 0", wv_cnt - wv0, fe_cnt - fe0);
    end
    check_outputs("ce_off");
    check_bank("ce_off");
    ce = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs("ce_on");
    $display("test_ce_drop: configured=%0b", configured);
  endtask

  task automatic test_random();
    int wv0, fe0, ewv, efe, n, ph;
    logic [63:0] b;
    ewv = 0; efe = 0;
    wv0 = wv_cnt; fe0 = fe_cnt;
    for (int f = 0; f < 100; f++) begin
      b = {$urandom, $urandom};
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 36)) : 32;
      ph = int'($urandom_range(2, 3));
      send_frame(b, n, ph);
      if (n == 32) begin
        model_commit(b[31:0]);
        ewv++;
        total++;
        if (word !== b[31:0]) begin
          bad++;
          $display("FAIL random_word %0d: got %08h expected %08h", f, word, b[31:0]);
        end
      end else begin
        efe++;
      end
      $display("test_random: frame %0d len %0d data %08h word %08h", f, n, b[31:0], word);
    end
    total++;
    if (wv_cnt - wv0 != ewv || fe_cnt - fe0 != efe) begin
      bad++;
      $display("FAIL random_pulses: got wv=%0d fe=%0d expected %0d %0d",
               wv_cnt - wv0, fe_cnt - fe0, ewv, efe);
    end
    check_outputs("random");
    check_bank("random");
  endtask

  task automatic test_reset_midframe();
    int wv0, fe0;
    logic [31:0] w;
    w = $urandom;
    shift_bits({32'h0, w}, 32, 2);   // full 32-bit stream shifted in first
    rst_n = 1'b0;                    // stream of 32 already counted; reset discards it
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    shift_bits({32'h0, w}, 16, 2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wv0 = wv_cnt; fe0 = fe_cnt;
    shift_bits({48'h0, w[15:0]}, 16, 2);
    pulse_le();
    total++;
    if (fe_cnt - fe0 != 1 || wv_cnt != wv0) begin
      bad++;
      $display("FAIL midframe_pulses: got fe=%0d wv=%0d expected 1 0", fe_cnt - fe0, wv_cnt - wv0);
    end
    check_outputs("midframe");
    check_bank("midframe");
    $display("test_reset_midframe: fe=%0d word=%08h", fe_cnt - fe0, word);
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_seq();
    test_bad_frames();
    test_ce_drop();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #20ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
